// File: rtl/esfrm_arb.sv
// esfrm_arb: round-robin arbiter for NCH peripheral masters onto the MCU ESFR port / Page0 RAM.
// Optional Page0 wait timeout is built only when ESFRM_ARB_TMO_EN is defined.
module esfrm_arb #(
  parameter int NCH = 2,
  parameter int AW  = 8,
  parameter int TMO = 15
) (
  input  logic              mclk,
  input  logic              srst,
  input  logic [NCH-1:0]    i_rd,
  input  logic [NCH-1:0]    i_wr,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*8-1:0]  wdat,
  output logic [NCH-1:0]    o_ack,
  output logic [NCH-1:0]    o_rrdy,
  output logic [7:0]        o_rdat,
  output logic [NCH-1:0]    o_gnt,
  output logic              esfrm_oe,
  output logic              esfrm_we,
  output logic [AW-2:0]     esfrm_adr,
  output logic [7:0]        esfrm_wdat,
  input  logic [7:0]        mcu_esfrrdat,
  output logic              pg0_acc,
  output logic              pg0_wr,
  input  logic [7:0]        pg0_rdat,
  input  logic              ramacc,
  output logic              tmo_err
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {IDLE, SFR, PG0, PG0RD, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [NCH-1:0]  req;
  logic            win_vld;
  logic [PW-1:0]   win_idx;
  logic [NCH-1:0]  win_gnt;
  logic [AW-1:0]   sel_addr;
  logic [7:0]      sel_wdat;
  logic            sel_wr;
  int              dist_c;
  int              best_d;
  logic            op_wr;
  logic            abort;

  assign req = i_rd | i_wr;

  // Winner is the requester closest after ptr in ascending order, with wrap.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = ptr;
    win_gnt  = '0;
    sel_addr = '0;
    sel_wdat = '0;
    sel_wr   = 1'b0;
    best_d   = NCH;
    dist_c   = 0;
    for (int c = 0; c < NCH; c++) begin
      dist_c = (c + NCH - 1 - int'(ptr)) % NCH;
      if (req[c] && dist_c < best_d) begin
        best_d   = dist_c;
        win_vld  = 1'b1;
        win_idx  = PW'(c);
        win_gnt  = '0;
        win_gnt[c] = 1'b1;
        sel_addr = addr[c*AW +: AW];
        sel_wdat = wdat[c*8 +: 8];
        sel_wr   = i_wr[c];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = sel_addr[AW-1] ? SFR : PG0;
      SFR:     state_nxt = DONE;
      PG0: begin
        if (!ramacc)    state_nxt = op_wr ? DONE : PG0RD;
        else if (abort) state_nxt = DONE;
      end
      PG0RD:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (srst) begin
      state      <= IDLE;
      ptr        <= PW'(NCH - 1);
      o_gnt      <= '0;
      op_wr      <= 1'b0;
      esfrm_adr  <= '0;
      esfrm_wdat <= '0;
      o_rdat     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_vld) begin
        ptr        <= win_idx;
        o_gnt      <= win_gnt;
        op_wr      <= sel_wr;
        esfrm_adr  <= sel_addr[AW-2:0];
        esfrm_wdat <= sel_wdat;
      end
      if (state == DONE) o_gnt <= '0;
      if (state == SFR && !op_wr) o_rdat <= mcu_esfrrdat;
      if (state == PG0RD) o_rdat <= pg0_rdat;
      if (abort) o_rdat <= 8'hFF;
    end
  end

  assign esfrm_oe = (state == SFR) && !op_wr;
  assign esfrm_we = (state == SFR) && op_wr;
  assign pg0_acc  = (state == PG0);
  assign pg0_wr   = (state == PG0) && op_wr;
  assign o_ack    = (state == DONE) ? o_gnt : '0;
  assign o_rrdy   = (state == DONE && !op_wr) ? o_gnt : '0;

`ifdef ESFRM_ARB_TMO_EN
  localparam int CW = $clog2(TMO + 2);

  logic [CW-1:0] wait_cnt;
  logic          tmo_flag;

  // Counter sits at zero outside PG0, so every Page0 access starts a fresh wait budget.
  always_ff @(posedge mclk) begin
    if (srst) begin
      wait_cnt <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (state != PG0)  wait_cnt <= '0;
      else if (ramacc)   wait_cnt <= wait_cnt + 1'b1;
      if (state == IDLE) tmo_flag <= 1'b0;
      else if (abort)    tmo_flag <= 1'b1;
    end
  end

  assign abort   = (state == PG0) && ramacc && (wait_cnt == CW'(TMO));
  assign tmo_err = (state == DONE) && tmo_flag;
`else
  assign abort   = 1'b0;
  assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_esfrm_arb.sv
// Directed bench for esfrm_arb (NCH=2, AW=8): vector table plus hand-written multi-cycle sequences.
module tb_esfrm_arb;

  localparam int NCH = 2;
  localparam int AW  = 8;
  localparam int TMO = 15;

  logic              mclk;
  logic              srst;
  logic [NCH-1:0]    i_rd, i_wr;
  logic [NCH*AW-1:0] addr;
  logic [NCH*8-1:0]  wdat;
  logic [NCH-1:0]    o_ack, o_rrdy, o_gnt;
  logic [7:0]        o_rdat;
  logic              esfrm_oe, esfrm_we;
  logic [AW-2:0]     esfrm_adr;
  logic [7:0]        esfrm_wdat;
  logic [7:0]        mcu_esfrrdat;
  logic              pg0_acc, pg0_wr;
  logic [7:0]        pg0_rdat;
  logic              ramacc;
  logic              tmo_err;

  int n_checks = 0;
  int n_fail   = 0;

  esfrm_arb #(.NCH(NCH), .AW(AW), .TMO(TMO)) dut (
    .mclk(mclk), .srst(srst), .i_rd(i_rd), .i_wr(i_wr), .addr(addr), .wdat(wdat),
    .o_ack(o_ack), .o_rrdy(o_rrdy), .o_rdat(o_rdat), .o_gnt(o_gnt),
    .esfrm_oe(esfrm_oe), .esfrm_we(esfrm_we), .esfrm_adr(esfrm_adr), .esfrm_wdat(esfrm_wdat),
    .mcu_esfrrdat(mcu_esfrrdat), .pg0_acc(pg0_acc), .pg0_wr(pg0_wr), .pg0_rdat(pg0_rdat),
    .ramacc(ramacc), .tmo_err(tmo_err)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct {
    logic [1:0]  rd, wr;
    logic [15:0] adr, wd;
    logic [7:0]  mdat, pdat;
    int          ch, lat;
    logic        oe, we, pacc, pwr;
    logic [6:0]  eadr;
    logic [7:0]  ewd;
    logic        rrdy;
    logic [7:0]  rdat;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check_output({name, "_a"}, {o_ack, o_rrdy, o_gnt, esfrm_oe, esfrm_we, pg0_acc, pg0_wr, tmo_err}, 32'h0);
    check_output({name, "_b"}, {o_rdat, esfrm_adr, esfrm_wdat}, 32'h0);
  endtask

  // Called in an IDLE cycle (cycle t); returns in the IDLE cycle after the ack.
  task automatic apply_stimulus(input int idx, input vec_t v);
    int k;
    logic [1:0] exp_g;
    exp_g = 2'b01 << v.ch;
    i_rd = v.rd; i_wr = v.wr; addr = v.adr; wdat = v.wd;
    mcu_esfrrdat = v.mdat; pg0_rdat = v.pdat; ramacc = 1'b0;
    step();
    check_output($sformatf("v%0d_strobes", idx), {esfrm_oe, esfrm_we, pg0_acc, pg0_wr},
                 {v.oe, v.we, v.pacc, v.pwr});
    check_output($sformatf("v%0d_adr", idx), esfrm_adr, v.eadr);
    check_output($sformatf("v%0d_gnt", idx), o_gnt, exp_g);
    if (v.wr != 2'b00) check_output($sformatf("v%0d_wdat", idx), esfrm_wdat, v.ewd);
    k = 1;
    while (o_ack == 2'b00 && k < 10) begin
      step();
      k++;
    end
    check_output($sformatf("v%0d_latency", idx), k, v.lat);
    check_output($sformatf("v%0d_ack", idx), o_ack, exp_g);
    check_output($sformatf("v%0d_rrdy", idx), o_rrdy, v.rrdy ? exp_g : 2'b00);
    check_output($sformatf("v%0d_tmo", idx), tmo_err, 1'b0);
    if (v.rrdy) check_output($sformatf("v%0d_rdat", idx), o_rdat, v.rdat);
    i_rd = 2'b00; i_wr = 2'b00;
    step();
  endtask

  initial begin
    int pacc_cnt;
    int ack_at;

    //          rd     wr     adr       wd        mdat   pdat   ch lat oe we pa pw eadr   ewd    rrdy rdat
    vecs[0] = '{2'b01, 2'b00, 16'h009A, 16'h0000, 8'h5C, 8'h00, 0, 2, 1, 0, 0, 0, 7'h1A, 8'h00, 1, 8'h5C};
    vecs[1] = '{2'b00, 2'b10, 16'hC300, 16'h7E00, 8'h00, 8'h00, 1, 2, 0, 1, 0, 0, 7'h43, 8'h7E, 0, 8'h00};
    vecs[2] = '{2'b01, 2'b01, 16'h0085, 16'h0033, 8'h99, 8'h00, 0, 2, 0, 1, 0, 0, 7'h05, 8'h33, 0, 8'h00};
    vecs[3] = '{2'b00, 2'b10, 16'h2200, 16'h1100, 8'h00, 8'h00, 1, 2, 0, 0, 1, 1, 7'h22, 8'h11, 0, 8'h00};
    vecs[4] = '{2'b01, 2'b00, 16'h007F, 16'h0000, 8'h00, 8'h3C, 0, 3, 0, 0, 1, 0, 7'h7F, 8'h00, 1, 8'h3C};
    vecs[5] = '{2'b11, 2'b00, 16'h80FF, 16'h0000, 8'hE1, 8'h00, 1, 2, 1, 0, 0, 0, 7'h00, 8'h00, 1, 8'hE1};
    vecs[6] = '{2'b00, 2'b11, 16'h0102, 16'hAA55, 8'h00, 8'h00, 0, 2, 0, 0, 1, 1, 7'h02, 8'h55, 0, 8'h00};

    srst = 1'b1; i_rd = '0; i_wr = '0; addr = '0; wdat = '0;
    mcu_esfrrdat = '0; pg0_rdat = '0; ramacc = 1'b0;
    step();
    step();
    check_idle_outputs("reset");
    srst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) apply_stimulus(i, vecs[i]);

    // Both channels hold SFR writes: ch0, then ch1 even though ch0 re-requests, then ch0.
    srst = 1'b1; step(); srst = 1'b0; step();
    i_wr = 2'b11; addr = 16'h8181; wdat = 16'h2211;
    step();
    check_output("rr_gnt0", o_gnt, 2'b01);
    check_output("rr_wdat0", esfrm_wdat, 8'h11);
    step();
    check_output("rr_ack0", o_ack, 2'b01);
    i_wr[0] = 1'b0;
    step();
    check_output("rr_idle_gnt", o_gnt, 2'b00);
    i_wr[0] = 1'b1;
    step();
    check_output("rr_gnt1", o_gnt, 2'b10);
    check_output("rr_wdat1", esfrm_wdat, 8'h22);
    step();
    check_output("rr_ack1", o_ack, 2'b10);
    i_wr[1] = 1'b0;
    step();
    step();
    check_output("rr_gnt0_again", o_gnt, 2'b01);
    step();
    check_output("rr_ack0_again", o_ack, 2'b01);
    i_wr = 2'b00;
    step();

    // ch1 Page0 read with three ramacc wait cycles.
    i_rd = 2'b10; addr = 16'h1000; pg0_rdat = 8'hA7; ramacc = 1'b1;
    pacc_cnt = 0; ack_at = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 4) ramacc = 1'b0;
      if (pg0_acc) pacc_cnt++;
      if (o_ack != 2'b00 && ack_at == 0) begin
        ack_at = k;
        check_output("pg0w_ack", o_ack, 2'b10);
        check_output("pg0w_rrdy", o_rrdy, 2'b10);
        check_output("pg0w_rdat", o_rdat, 8'hA7);
        i_rd = 2'b00;
      end
    end
    check_output("pg0w_latency", ack_at, 6);
    check_output("pg0w_acc_cycles", pacc_cnt, 4);

    // Reset in the middle of a Page0 wait aborts silently and restarts at ch0.
    i_rd = 2'b10; addr = 16'h2000; ramacc = 1'b1;
    step();
    check_output("srst_in_pg0", pg0_acc, 1'b1);
    step();
    srst = 1'b1;
    step();
    srst = 1'b0; ramacc = 1'b0;
    check_idle_outputs("srst_mid");
    i_rd = 2'b11; addr = 16'h8080; mcu_esfrrdat = 8'h6D;
    step();
    check_output("srst_next_gnt", o_gnt, 2'b01);
    step();
    check_output("srst_next_ack", o_ack, 2'b01);
    check_output("srst_next_rdat", o_rdat, 8'h6D);
    i_rd = 2'b00;
    step();

`ifdef ESFRM_ARB_TMO_EN
    // Page0 read with ramacc stuck high times out 16 cycles after PG0 entry.
    i_rd = 2'b01; addr = 16'h0011; ramacc = 1'b1; ack_at = 0;
    for (int k = 1; k <= 40 && ack_at == 0; k++) begin
      step();
      if (o_ack != 2'b00) begin
        ack_at = k;
        check_output("tmo_err", tmo_err, 1'b1);
        check_output("tmo_rdat", o_rdat, 8'hFF);
        check_output("tmo_rrdy", o_rrdy, 2'b01);
        i_rd = 2'b00;
      end
    end
    check_output("tmo_latency", ack_at, 17);
    ramacc = 1'b0;
    step();
    check_output("tmo_err_clear", tmo_err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
